// File: rtl/cmp_seq_display_ctrl.sv
// Two-operand load/compare sequencer for the 3-bit comparator lab, with an 8-digit
// multiplexed 7-segment scanner showing A, the relation symbol and B.
module cmp_seq_display_ctrl #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sw,
  input  logic       btn_load,
  input  logic       btn_clr,
  output logic [2:0] O,
  output logic [1:0] dbg_state,
  output logic [7:0] seg_data,
  output logic [7:0] seg_com
);

  localparam int             PW        = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(SCAN_DIV - 1);

  localparam logic [1:0] S_A    = 2'd0;
  localparam logic [1:0] S_B    = 2'd1;
  localparam logic [1:0] S_CMP  = 2'd2;
  localparam logic [1:0] S_SHOW = 2'd3;

  localparam logic [7:0] SYM_GT = 8'b0110_0010;
  localparam logic [7:0] SYM_EQ = 8'b0001_0010;
  localparam logic [7:0] SYM_LT = 8'b0000_1110;

  logic          load_s1_q, load_s2_q, load_prev_q;
  logic          clr_s1_q, clr_s2_q, clr_prev_q;
  logic          load_s1_d, load_s2_d, load_prev_d;
  logic          clr_s1_d, clr_s2_d, clr_prev_d;
  logic          load_pulse, clr_pulse;

  logic [1:0]    state_q, state_d;
  logic [2:0]    a_q, a_d, b_q, b_d, o_q, o_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    seg_data_q, seg_data_d, seg_com_q, seg_com_d;

  function automatic logic [7:0] hex_font(input logic [2:0] v);
    logic [7:0] f;
    case (v)
      3'd0:    f = 8'hFC;
      3'd1:    f = 8'h60;
      3'd2:    f = 8'hDA;
      3'd3:    f = 8'hF2;
      3'd4:    f = 8'h66;
      3'd5:    f = 8'hB6;
      3'd6:    f = 8'hBE;
      default: f = 8'hE0;
    endcase
    return f;
  endfunction

  // Buttons are raw and asynchronous: two sync stages, then a one-clock rising-edge pulse.
  always_comb begin
    load_s1_d   = btn_load;
    load_s2_d   = load_s1_q;
    load_prev_d = load_s2_q;
    clr_s1_d    = btn_clr;
    clr_s2_d    = clr_s1_q;
    clr_prev_d  = clr_s2_q;
    load_pulse  = load_s2_q & ~load_prev_q;
    clr_pulse   = clr_s2_q & ~clr_prev_q;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    o_d     = o_q;
    if (clr_pulse) begin
      state_d = S_A;
      a_d     = 3'd0;
      b_d     = 3'd0;
      o_d     = 3'b000;
    end else begin
      case (state_q)
        S_A: if (load_pulse) begin
          a_d     = sw;
          state_d = S_B;
        end
        S_B: if (load_pulse) begin
          b_d     = sw;
          state_d = S_CMP;
        end
        S_CMP: begin
          o_d     = {a_q > b_q, a_q == b_q, a_q < b_q};
          state_d = S_SHOW;
        end
        default: if (load_pulse) begin
          a_d     = sw;
          o_d     = 3'b000;
          state_d = S_B;
        end
      endcase
    end
  end

  always_comb begin
    presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
    idx_d   = (presc_q == PRESC_MAX) ? idx_q + 3'd1 : idx_q;
    seg_com_d  = ~(8'b1 << idx_q);
    seg_data_d = 8'h00;
    case (idx_q)
      3'd4: seg_data_d = (state_q == S_A) ? hex_font(sw) : hex_font(a_q);
      3'd2: if (state_q == S_SHOW) begin
        case (o_q)
          3'b100:  seg_data_d = SYM_GT;
          3'b010:  seg_data_d = SYM_EQ;
          3'b001:  seg_data_d = SYM_LT;
          default: seg_data_d = 8'h00;
        endcase
      end
      3'd0: begin
        if (state_q == S_B)      seg_data_d = hex_font(sw);
        else if (state_q != S_A) seg_data_d = hex_font(b_q);
      end
      default: seg_data_d = 8'h00;
    endcase
  end

  // NOTE: all state updates use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_s1_q   <= 1'b0;
      load_s2_q   <= 1'b0;
      load_prev_q <= 1'b0;
      clr_s1_q    <= 1'b0;
      clr_s2_q    <= 1'b0;
      clr_prev_q  <= 1'b0;
      state_q     <= S_A;
      a_q         <= 3'd0;
      b_q         <= 3'd0;
      o_q         <= 3'b000;
      presc_q     <= '0;
      idx_q       <= 3'd0;
      seg_data_q  <= 8'h00;
      seg_com_q   <= 8'hFF;
    end else begin
      load_s1_q   <= load_s1_d;
      load_s2_q   <= load_s2_d;
      load_prev_q <= load_prev_d;
      clr_s1_q    <= clr_s1_d;
      clr_s2_q    <= clr_s2_d;
      clr_prev_q  <= clr_prev_d;
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      o_q         <= o_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      seg_data_q  <= seg_data_d;
      seg_com_q   <= seg_com_d;
    end
  end

  assign O         = o_q;
  assign dbg_state = state_q;
  assign seg_data  = seg_data_q;
  assign seg_com   = seg_com_q;

endmodule

// File: tb/tb_cmp_seq_display_ctrl.sv
// Bench for cmp_seq_display_ctrl: directed and random load/clear sequences compared every
// clock against a cycle-counting behavioural model of the sequencer and display scan.
module tb_cmp_seq_display_ctrl;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] sw = 3'd0;
  logic       btn_load = 1'b0;
  logic       btn_clr = 1'b0;
  logic [2:0] O;
  logic [1:0] dbg_state;
  logic [7:0] seg_data;
  logic [7:0] seg_com;

  cmp_seq_display_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_load(btn_load), .btn_clr(btn_clr),
    .O(O), .dbg_state(dbg_state), .seg_data(seg_data), .seg_com(seg_com)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: state 0=A 1=B 2=CMP 3=SHOW, operands, flags, edges since reset, button samples.
  int         m_state, m_a, m_b, cyc;
  logic [2:0] m_o;
  bit         lh [3];
  bit         ch [3];
  logic [7:0] font [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] digit_exp(input int idx, input int st, input int a, input int b,
                                           input logic [2:0] o, input logic [2:0] s);
    logic [7:0] r;
    r = 8'h00;
    if (idx == 4) r = (st == 0) ? font[s] : font[a[2:0]];
    if (idx == 0 && st == 1) r = font[s];
    if (idx == 0 && st >= 2) r = font[b[2:0]];
    if (idx == 2 && st == 3) r = (o == 3'b100) ? 8'h62 : (o == 3'b010) ? 8'h12 :
                                 (o == 3'b001) ? 8'h0E : 8'h00;
    return r;
  endfunction

  task automatic model_reset();
    m_state = 0; m_a = 0; m_b = 0; m_o = 3'b000; cyc = 0;
    for (int i = 0; i < 3; i++) begin
      lh[i] = 1'b0;
      ch[i] = 1'b0;
    end
  endtask

  // One clock: advance the model on the edge, then compare all outputs 1 time unit later.
  task automatic tick();
    int idx;
    logic [7:0] exp_com, exp_data;
    bit ld, cl;
    @(posedge clk);
    idx      = (cyc / SCAN_DIV) % 8;
    exp_com  = ~(8'b1 << idx);
    exp_data = digit_exp(idx, m_state, m_a, m_b, m_o, sw);
    cyc++;
    ld = lh[1] & ~lh[2];
    cl = ch[1] & ~ch[2];
    lh[2] = lh[1]; lh[1] = lh[0]; lh[0] = btn_load;
    ch[2] = ch[1]; ch[1] = ch[0]; ch[0] = btn_clr;
    if (cl) begin
      m_state = 0; m_a = 0; m_b = 0; m_o = 3'b000;
    end else if (m_state == 2) begin
      m_o = (m_a > m_b) ? 3'b100 : (m_a == m_b) ? 3'b010 : 3'b001;
      m_state = 3;
    end else if (ld) begin
      if (m_state == 1) begin
        m_b = int'(sw);
        m_state = 2;
      end else begin
        m_a = int'(sw);
        m_o = 3'b000;
        m_state = 1;
      end
    end
    #1;
    check("O", O, m_o);
    check("dbg_state", dbg_state, m_state);
    check("seg_com", seg_com, exp_com);
    check("seg_data", seg_data, exp_data);
  endtask

  task automatic press(input logic [2:0] v, input int hold);
    sw = v;
    btn_load = 1'b1;
    repeat (hold) tick();
    btn_load = 1'b0;
    repeat (4) tick();
  endtask

  task automatic press_clr();
    btn_clr = 1'b1;
    repeat (2) tick();
    btn_clr = 1'b0;
    repeat (4) tick();
  endtask

  task automatic expect_digit(input string tag, input int d, input logic [7:0] exp);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (seg_com === ~(8'b1 << d)) found = 1'b1;
    end
    check({tag, "_reached"}, found, 1);
    check(tag, seg_data, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_com"}, seg_com, 8'hFF);
    check({tag, "_data"}, seg_data, 8'h00);
    check({tag, "_O"}, O, 3'b000);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    logic [2:0] ra, rb;
    font = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0};
    model_reset();

    #1 rst = 1'b1;
    #1 check_reset_outputs("reset");
    @(negedge clk) rst = 1'b0;
    tick();
    check("first_com", seg_com, 8'hFE);

    press(3'd5, 2);
    press(3'd2, 2);
    check("o_5v2", O, 3'b100);
    expect_digit("d2_gt", 2, 8'h62);
    expect_digit("d4_a5", 4, 8'hB6);
    expect_digit("d0_b2", 0, 8'hDA);

    press(3'd3, 2);
    press(3'd3, 2);
    check("o_3v3", O, 3'b010);
    expect_digit("d2_eq", 2, 8'h12);
    press(3'd1, 1);
    press(3'd6, 3);
    check("o_1v6", O, 3'b001);
    expect_digit("d2_lt", 2, 8'h0E);
    press(3'd7, 2);
    press(3'd0, 2);
    check("o_7v0", O, 3'b100);

    for (int i = 0; i < 40; i++) begin
      tick();
      check("one_cold", $countones(~seg_com), 1);
    end

    press(3'd4, 2);
    check("in_s_b", dbg_state, 1);
    sw = 3'd6;
    btn_load = 1'b1;
    btn_clr = 1'b1;
    repeat (2) tick();
    btn_load = 1'b0;
    btn_clr = 1'b0;
    repeat (4) tick();
    check("clr_wins_state", dbg_state, 0);
    check("clr_wins_O", O, 3'b000);

    sw = 3'd2;
    btn_load = 1'b1;
    repeat (50) tick();
    btn_load = 1'b0;
    repeat (4) tick();
    check("held_one_step", dbg_state, 1);

    press(3'd5, 2);
    check("pre_rst_show", dbg_state, 3);
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    model_reset();
    @(negedge clk) rst = 1'b0;
    tick();

    for (int r = 0; r < 20; r++) begin
      ra = 3'($urandom_range(0, 7));
      rb = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) press_clr();
      press(ra, $urandom_range(1, 5));
      repeat ($urandom_range(0, 6)) tick();
      press(rb, $urandom_range(1, 5));
      repeat ($urandom_range(2, 12)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
